// File: rtl/rd_burst_scheduler_if.sv
// R-channel sharing bundle for rd_burst_scheduler: source-side payloads and
// handshakes, the muxed master-side R channel, AR throttle and status.
interface rd_burst_scheduler_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 79
);
    logic [NUM_SRC*DATA_W-1:0] DATA_IN;
    logic [NUM_SRC-1:0]        VALID_IN;
    logic [NUM_SRC-1:0]        READY_IN;
    logic [DATA_W-1:0]         DATA;
    logic                      VALID;
    logic                      READY;
    logic [NUM_SRC-1:0]        AR_FIRE;
    logic [NUM_SRC-1:0]        AR_BLOCK;
    logic [NUM_SRC-1:0]        GRANT;
    logic                      ERR;

    modport slave (
        input  DATA_IN, VALID_IN, READY, AR_FIRE,
        output READY_IN, DATA, VALID, AR_BLOCK, GRANT, ERR
    );

    modport master (
        output DATA_IN, VALID_IN, READY, AR_FIRE,
        input  READY_IN, DATA, VALID, AR_BLOCK, GRANT, ERR
    );
endinterface

// File: rtl/rd_burst_scheduler.sv
// Round-robin, burst-locked R-channel scheduler with per-source outstanding
// read tracking. Define RD_BURST_SCHED_WDOG_EN to build the stall watchdog.
module rd_burst_scheduler #(
    parameter int NUM_SRC         = 4,
    parameter int DATA_W          = 79,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = 4,
    parameter int WDOG_CYCLES     = 1024
) (
    input logic                 CLK,
    input logic                 RESETn,
    rd_burst_scheduler_if.slave bus
);
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] grant_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_ptr_nxt;
    logic [CNT_W-1:0]   cnt [NUM_SRC];
    logic [CNT_W-1:0]   cnt_nxt [NUM_SRC];
    logic [NUM_SRC-1:0] ar_block;
    logic [NUM_SRC-1:0] ar_block_nxt;
    logic               err;
    logic               err_nxt;

    logic [DATA_W-1:0]  mux_data;
    logic               mux_valid;
    logic [NUM_SRC-1:0] mux_ready;
    logic               fire;
    logic               last_fire;
    logic [NUM_SRC-1:0] rlast_src;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic               wdog_trip;

    // Everything master-facing is steered purely by the registered grant
    always_comb begin
        mux_data  = '0;
        mux_valid = 1'b0;
        mux_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                mux_data     = bus.DATA_IN[i*DATA_W +: DATA_W];
                mux_valid    = bus.VALID_IN[i];
                mux_ready[i] = bus.READY;
            end
        end
    end

    assign bus.DATA     = mux_data;
    assign bus.VALID    = mux_valid;
    assign bus.READY_IN = mux_ready;
    assign bus.GRANT    = grant;
    assign bus.AR_BLOCK = ar_block;
    assign bus.ERR      = err;

    assign fire      = mux_valid & bus.READY;
    assign last_fire = fire & mux_data[0];
    assign rlast_src = last_fire ? grant : '0;

    // First requester strictly after the last winner, wrapping around
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr;
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (!win_found &&
                bus.VALID_IN[(int'(rr_ptr) + k) % NUM_SRC]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(rr_ptr) + k) % NUM_SRC);
            end
        end
    end

`ifdef RD_BURST_SCHED_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] stall;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            stall <= '0;
        end else if (state != LOCK || fire) begin
            stall <= '0;
        end else begin
            stall <= stall + WD_W'(1);
        end
    end

    // Trips on the WDOG_CYCLES-th consecutive LOCK cycle without a beat
    assign wdog_trip = (state == LOCK) && !fire &&
                       (stall == WD_W'(WDOG_CYCLES - 1));
`else
    assign wdog_trip = (WDOG_CYCLES < 0);
`endif

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        rr_ptr_nxt = rr_ptr;
        unique case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt  = LOCK;
                    grant_nxt  = NUM_SRC'(1) << win_idx;
                    rr_ptr_nxt = win_idx;
                end
            end
            LOCK: begin
                // rr_ptr already names the locked source, so a watchdog
                // release naturally resumes the scan just past it
                if (last_fire || wdog_trip) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end
            end
        endcase
    end

    always_comb begin
        err_nxt = err | wdog_trip;
        for (int i = 0; i < NUM_SRC; i++) begin
            cnt_nxt[i] = cnt[i];
            if (bus.AR_FIRE[i] && !rlast_src[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    err_nxt = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end else if (rlast_src[i] && !bus.AR_FIRE[i]) begin
                if (cnt[i] == '0) begin
                    err_nxt = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] - CNT_W'(1);
                end
            end
            ar_block_nxt[i] = (cnt_nxt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= IDX_W'(NUM_SRC - 1);
            ar_block <= '0;
            err      <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            rr_ptr   <= rr_ptr_nxt;
            ar_block <= ar_block_nxt;
            err      <= err_nxt;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end
endmodule

// File: tb/tb_rd_burst_scheduler.sv
// Bench for rd_burst_scheduler: directed scenarios plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_rd_burst_scheduler;
    localparam int NS   = 4;
    localparam int DW   = 79;
    localparam int MAXO = 2;
    localparam int CW   = 2;
    localparam int WD   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rd_burst_scheduler_if #(.NUM_SRC(NS), .DATA_W(DW)) bus ();

    rd_burst_scheduler #(
        .NUM_SRC(NS),
        .DATA_W(DW),
        .MAX_OUTSTANDING(MAXO),
        .CNT_W(CW),
        .WDOG_CYCLES(WD)
    ) u_dut (
        .CLK(clk),
        .RESETn(rst_n),
        .bus(bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // stimulus state
    logic [DW-1:0] pay [NS];
    int            left [NS];
    logic [NS-1:0] en;
    logic [NS-1:0] arf;
    logic [NS-1:0] vdrv;
    logic          rdy;
    int            rs_pct;
    int            blen;

    // reference model: owner = locked source or -1, ptr = last winner
    int owner;
    int ptr;
    int cnt [NS];
    int stall;
    bit err;

    logic [NS-1:0] glog [$];

    task automatic chk(string tag, logic [95:0] obs, logic [95:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mkbeat(bit last);
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        r[0] = last;
        return r[DW-1:0];
    endfunction

    task automatic start_burst(int i, int n);
        left[i] = n;
        pay[i]  = mkbeat(n == 1);
    endtask

    task automatic drive();
        logic [NS*DW-1:0] d;
        for (int i = 0; i < NS; i++) begin
            if (left[i] == 0 && $urandom_range(0, 99) < rs_pct)
                start_burst(i, blen > 0 ? blen : $urandom_range(1, 4));
            vdrv[i] = (left[i] > 0) && en[i];
            d[i*DW +: DW] = pay[i];
        end
        bus.DATA_IN  = d;
        bus.VALID_IN = vdrv;
        bus.READY    = rdy;
        bus.AR_FIRE  = arf;
    endtask

    task automatic check_outputs();
        logic [NS-1:0] eg;
        logic [NS-1:0] eb;
        eg = (owner < 0) ? '0 : NS'(1) << owner;
        for (int i = 0; i < NS; i++) eb[i] = (cnt[i] == MAXO);
        chk("grant", bus.GRANT, eg);
        chk("valid", bus.VALID, (owner >= 0) ? vdrv[owner] : 1'b0);
        chk("ready_in", bus.READY_IN, rdy ? eg : '0);
        if (owner >= 0) chk("data", bus.DATA, pay[owner]);
        else chk("data", bus.DATA, '0);
        chk("ar_block", bus.AR_BLOCK, eb);
        chk("err", bus.ERR, err);
        glog.push_back(bus.GRANT);
    endtask

    task automatic step();
        int  old;
        bit  fr;
        bit  lst;
        bit  got;
        old = owner;
        fr  = 1'b0;
        lst = 1'b0;
        if (old >= 0) begin
            fr  = vdrv[old] && rdy;
            lst = fr && pay[old][0];
        end
        for (int i = 0; i < NS; i++) begin
            bit inc;
            bit dec;
            inc = arf[i];
            dec = lst && (old == i);
            if (inc && !dec) begin
                if (cnt[i] == MAXO) err = 1'b1;
                else cnt[i]++;
            end else if (dec && !inc) begin
                if (cnt[i] == 0) err = 1'b1;
                else cnt[i]--;
            end
        end
        if (old < 0) begin
            got   = 1'b0;
            stall = 0;
            for (int k = 1; k <= NS; k++) begin
                if (!got && vdrv[(ptr + k) % NS]) begin
                    got   = 1'b1;
                    owner = (ptr + k) % NS;
                end
            end
            if (got) ptr = owner;
        end else if (lst) begin
            owner = -1;
        end else begin
`ifdef RD_BURST_SCHED_WDOG_EN
            if (fr) begin
                stall = 0;
            end else begin
                stall++;
                if (stall == WD) begin
                    owner = -1;
                    err   = 1'b1;
                    stall = 0;
                end
            end
`endif
        end
        if (fr) begin
            left[old]--;
            pay[old] = mkbeat(left[old] == 1);
        end
    endtask

    task automatic tick();
        drive();
        #1;
        check_outputs();
        @(posedge clk);
        step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        en     = '1;
        rdy    = 1'b0;
        arf    = '0;
        rs_pct = 0;
        blen   = 0;
        for (int i = 0; i < NS; i++) begin
            left[i] = 0;
            pay[i]  = '0;
        end
        drive();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_grant", bus.GRANT, '0);
        chk("rst_err", bus.ERR, 1'b0);
        chk("rst_block", bus.AR_BLOCK, '0);
        @(negedge clk);
        owner = -1;
        ptr   = NS - 1;
        stall = 0;
        err   = 1'b0;
        for (int i = 0; i < NS; i++) cnt[i] = 0;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NS-1:0] t1 [6];
        logic [NS-1:0] t2 [15];

        t1 = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0};
        t2 = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0,
               4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1};

        // single 4-beat burst from source 0
        do_reset();
        rdy = 1'b1;
        start_burst(0, 4);
        glog.delete();
        repeat (6) tick();
        for (int k = 0; k < 6; k++)
            chk($sformatf("t1_grant%0d", k), glog[k], t1[k]);

        // all sources busy, 2-beat bursts: strict rotation with idle gaps
        do_reset();
        rdy    = 1'b1;
        rs_pct = 100;
        blen   = 2;
        glog.delete();
        repeat (15) tick();
        for (int k = 0; k < 15; k++)
            chk($sformatf("t2_grant%0d", k), glog[k], t2[k]);

        // source 1 holds the lock against source 0
        do_reset();
        rdy = 1'b1;
        start_burst(1, 6);
        repeat (2) tick();
        start_burst(0, 2);
        for (int k = 0; k < 6; k++) begin
            rdy = k[0];
            tick();
            chk("t3_grant", bus.GRANT, 4'h2);
            chk("t3_rdy0", bus.READY_IN[0], 1'b0);
        end
        rdy = 1'b1;
        repeat (2) tick();
        chk("t3_release", bus.GRANT, 4'h0);
        tick();
        chk("t3_next", bus.GRANT, 4'h1);

        // outstanding tracking on source 2
        do_reset();
        rdy = 1'b1;
        arf = 4'b0100;
        repeat (2) tick();
        arf = '0;
        chk("t4_blk_set", bus.AR_BLOCK[2], 1'b1);
        start_burst(2, 1);
        repeat (2) tick();
        chk("t4_blk_clr", bus.AR_BLOCK[2], 1'b0);
        start_burst(2, 1);
        tick();
        arf = 4'b0100;
        tick();
        arf = '0;
        chk("t4_same_cyc", bus.AR_BLOCK[2], 1'b0);
        arf = 4'b0100;
        tick();
        arf = '0;
        chk("t4_blk_again", bus.AR_BLOCK[2], 1'b1);
        chk("t4_no_err", bus.ERR, 1'b0);

        // underflow error on source 3
        do_reset();
        rdy = 1'b1;
        start_burst(3, 1);
        repeat (2) tick();
        chk("t5_uflow_err", bus.ERR, 1'b1);
        repeat (3) tick();
        chk("t5_err_sticky", bus.ERR, 1'b1);

        // overflow error and saturation on source 2
        do_reset();
        rdy = 1'b1;
        arf = 4'b0100;
        repeat (3) tick();
        arf = '0;
        chk("t5_oflow_err", bus.ERR, 1'b1);
        chk("t5_sat_blk", bus.AR_BLOCK[2], 1'b1);
        start_burst(2, 1);
        repeat (2) tick();
        chk("t5_sat_dec", bus.AR_BLOCK[2], 1'b0);

`ifdef RD_BURST_SCHED_WDOG_EN
        // stalled source 0 is dropped, pending source 1 follows
        do_reset();
        rdy = 1'b0;
        start_burst(0, 3);
        tick();
        start_burst(1, 1);
        repeat (WD) tick();
        chk("t6_wdog_drop", bus.GRANT, 4'h0);
        chk("t6_wdog_err", bus.ERR, 1'b1);
        tick();
        chk("t6_wdog_next", bus.GRANT, 4'h2);
`endif

        // random traffic
        do_reset();
        rs_pct = 30;
        blen   = 0;
        for (int c = 0; c < 3000; c++) begin
            en  = NS'($urandom());
            rdy = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NS; i++)
                arf[i] = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rd_burst_scheduler.md
Name: rd_burst_scheduler

Overview:
- N-way scheduler for the AXI4 read-data (R) return path: shares one master-side R channel between NUM_SRC slave-side R sources.
- Grants sources round-robin and holds each grant for a whole burst, releasing it on the RLAST beat.
- Also tracks outstanding read bursts per source from AR handshakes and throttles AR issue per source.
- Sits between the slave ports and the master port of the bus fabric; muxes the 79-bit R payload under its own grant.

Parameters:
- NUM_SRC, 4, number of R sources (2..8).
- DATA_W, 79, R payload width; bit 0 is RLAST.
- MAX_OUTSTANDING, 8, maximum in-flight read bursts per source (1..255).
- CNT_W, 4, outstanding counter width; must satisfy 2^CNT_W > MAX_OUTSTANDING.
- WDOG_CYCLES, 1024, stall limit for the optional watchdog.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RESETn  in  1  asynchronous active-low reset.
- DATA_IN  in  NUM_SRC*DATA_W  source payloads; source i occupies bits [i*DATA_W +: DATA_W].
- VALID_IN  in  NUM_SRC  per-source RVALID.
- READY_IN  out  NUM_SRC  per-source RREADY.
- DATA  out  DATA_W  muxed payload to master.
- VALID  out  1  muxed RVALID.
- READY  in  1  master RREADY.
- AR_FIRE  in  NUM_SRC  one-cycle pulse per source when an AR handshake to that source completes.
- AR_BLOCK  out  NUM_SRC  1 = source at MAX_OUTSTANDING; the upstream AR mux must not issue to it.
- GRANT  out  NUM_SRC  one-hot registered grant; all zero when idle.
- ERR  out  1  sticky protocol error flag.

Behaviour:
- Reset (async, RESETn=0):
  - state=IDLE; GRANT=0; rr_ptr=NUM_SRC-1, so source 0 has first priority.
  - All counters 0; ERR=0; AR_BLOCK=0.
  - Reset mid-burst discards the burst with no recovery.
- Outputs are combinational from the registered GRANT:
  - If GRANT[i]: DATA=source i payload, VALID=VALID_IN[i], READY_IN[i]=READY, all other READY_IN=0.
  - If GRANT=0: DATA=0, VALID=0, READY_IN=0.
- State IDLE:
  - If any VALID_IN is set, pick the first requesting source scanning upward from rr_ptr+1 (mod NUM_SRC).
  - Register GRANT to that source and go to LOCK; rr_ptr is set to the winner.
  - Arbitration latency is 1 cycle: the first beat can transfer in the cycle after VALID_IN is sampled.
  - No requests: stay IDLE with GRANT=0.
- State LOCK:
  - The grant does not change regardless of other requests.
  - A beat transfers when VALID && READY.
  - A transfer with DATA[0]=1 (RLAST): next cycle GRANT=0 and state=IDLE.
  - Back-to-back bursts therefore have one idle cycle between them.
  - A non-last beat stays in LOCK.
- Outstanding counter per source i:
  - Increments on AR_FIRE[i].
  - Decrements on an RLAST transfer from source i.
  - Both in the same cycle: unchanged.
  - AR_BLOCK[i] = (cnt[i] == MAX_OUTSTANDING), registered from the counter value.
  - AR_FIRE[i] while cnt==MAX_OUTSTANDING: counter saturates and ERR is set.
  - RLAST from source i with cnt[i]==0: counter stays 0 and ERR is set.
- The scheduler does not gate arbitration on counter values; R data is always accepted.
- ERR is cleared only by reset.

Optional Feature:
- Macro RD_BURST_SCHED_WDOG_EN.
- Defined:
  - A stall counter runs in LOCK and clears on every beat transfer.
  - When it reaches WDOG_CYCLES with no transfer, the scheduler forces GRANT=0 and IDLE, advances rr_ptr past the stalled source, and sets ERR.
  - The stalled source's counter is left unchanged.
- Undefined: no watchdog logic is built; LOCK persists indefinitely.

Test Plan:
- Reset, then VALID_IN=4'b0001 with a 4-beat burst (RLAST on beat 4), READY=1 → GRANT=0001 one cycle later; 4 beats pass with data intact; GRANT=0 the cycle after the last beat.
- VALID_IN=4'b1111 held, every burst 2 beats → grants 0001, 0010, 0100, 1000, 0001 with one idle cycle between bursts.
- While source 1 is locked mid-burst, raise VALID_IN[0] and toggle READY → GRANT stays 0010 until RLAST; READY_IN[0] stays 0 throughout.
- MAX_OUTSTANDING=2: two AR_FIRE[2] pulses → AR_BLOCK[2]=1; one RLAST from source 2 → AR_BLOCK[2]=0. AR_FIRE[2] and RLAST from source 2 in the same cycle → count unchanged.
- RLAST from source 3 with cnt[3]=0 → ERR=1 and stays set; a third AR_FIRE at cnt=MAX → ERR=1 and count stays at MAX.
- With RD_BURST_SCHED_WDOG_EN and WDOG_CYCLES=16: lock source 0, hold READY=0 for 16 cycles → GRANT=0, ERR=1; a pending source 1 is granted next.
